// File: rtl/turn_engine.sv
// Tic-tac-toe gameplay datapath: board, player cursor, turn timer and PC move choice.
// Turns the controller's one-hot state flags into its event inputs.
module turn_engine #(
    parameter int unsigned TURN_CYCLES = 500000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startState,
    input  logic        playState,
    input  logic        pcState,
    input  logic        winState,
    input  logic        loseState,
    input  logic        btnNext,
    input  logic        btnSelect,
    output logic        timeExpired,
    output logic        playerMov,
    output logic        playerWin,
    output logic        pcWin,
    output logic [17:0] board,
    output logic [3:0]  cursor
);

    localparam int unsigned TW = $clog2(TURN_CYCLES);
    // Timer value in the cycle before it reaches TURN_CYCLES-1.
    localparam logic [TW-1:0] TIMER_PRE = TW'(TURN_CYCLES - 2);
    localparam logic [8:0] CORNERS = 9'b101000101;
    // Eight 9-bit cell masks: rows, columns, diagonals.
    localparam logic [71:0] LINES = {
        9'b001010100, 9'b100010001,
        9'b100100100, 9'b010010010, 9'b001001001,
        9'b111000000, 9'b000111000, 9'b000000111
    };

    function automatic logic [3:0] lowest(input logic [8:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    logic [17:0]   board_q, board_d;
    logic [3:0]    cursor_q, cursor_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic          play_q;
    logic          mov_q, mov_d;
    logic          exp_q, exp_d;

    logic [8:0] empty, pmark, cmark;
    logic [8:0] win_cells, blk_cells, line_m;
    logic [8:0] pc_sel, c_after, empty_after, above;
    logic [3:0] pc_cell, next_cur;
    logic       any_empty, player_line, pc_line_after, frozen;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            empty[i] = (board_q[2*i +: 2] == 2'b00);
            pmark[i] = (board_q[2*i +: 2] == 2'b01);
            cmark[i] = (board_q[2*i +: 2] == 2'b10);
        end
    end

    assign any_empty = |empty;

    // Candidate cells that would complete a PC line or block a player line.
    always_comb begin
        win_cells   = '0;
        blk_cells   = '0;
        player_line = 1'b0;
        line_m      = '0;
        for (int l = 0; l < 8; l++) begin
            line_m = LINES[9*l +: 9];
            if ((pmark & line_m) == line_m) player_line = 1'b1;
            if ($countones(cmark & line_m) == 2 && (empty & line_m) != '0)
                win_cells = win_cells | (empty & line_m);
            if ($countones(pmark & line_m) == 2 && (empty & line_m) != '0)
                blk_cells = blk_cells | (empty & line_m);
        end
    end

    always_comb begin
        if (win_cells != '0)                 pc_cell = lowest(win_cells);
        else if (blk_cells != '0)            pc_cell = lowest(blk_cells);
        else if (empty[4])                   pc_cell = 4'd4;
        else if ((empty & CORNERS) != '0)    pc_cell = lowest(empty & CORNERS);
        else                                 pc_cell = lowest(empty);
    end

    assign pc_sel      = any_empty ? (9'(1) << pc_cell) : '0;
    assign c_after     = cmark | pc_sel;
    assign empty_after = empty & ~pc_sel;

    always_comb begin
        pc_line_after = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if ((c_after & LINES[9*l +: 9]) == LINES[9*l +: 9]) pc_line_after = 1'b1;
        end
    end

    // A draw is reported to the controller as a PC win.
    assign playerWin = pcState & player_line;
    assign pcWin     = pcState & (pc_line_after | ~(|empty_after) | ~any_empty);

    always_comb begin
        for (int i = 0; i < 9; i++) above[i] = (4'(i) > cursor_q);
        if ((empty & above) != '0) next_cur = lowest(empty & above);
        else if (any_empty)        next_cur = lowest(empty);
        else                       next_cur = cursor_q;
    end

    assign frozen = winState | loseState;

    always_comb begin
        board_d  = board_q;
        cursor_d = cursor_q;
        timer_d  = timer_q;
        done_d   = done_q;
        mov_d    = 1'b0;
        exp_d    = 1'b0;
        if (startState) begin
            board_d  = '0;
            cursor_d = 4'd0;
            timer_d  = '0;
            done_d   = 1'b0;
        end else if (!frozen) begin
            if (playState && !play_q) begin
                timer_d  = '0;
                done_d   = 1'b0;
                cursor_d = lowest(empty);
            end else if (playState && !done_q) begin
                // A valid select takes precedence over both advance and expiry.
                if (btnSelect && empty[cursor_q]) begin
                    board_d[{cursor_q, 1'b0} +: 2] = 2'b01;
                    mov_d  = 1'b1;
                    done_d = 1'b1;
                end else begin
                    if (btnNext && !btnSelect) cursor_d = next_cur;
                    timer_d = timer_q + 1'b1;
                    if (timer_q == TIMER_PRE) begin
                        exp_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            if (pcState && !player_line && any_empty)
                board_d[{pc_cell, 1'b0} +: 2] = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board_q  <= '0;
            cursor_q <= 4'd0;
            timer_q  <= '0;
            done_q   <= 1'b0;
            play_q   <= 1'b0;
            mov_q    <= 1'b0;
            exp_q    <= 1'b0;
        end else begin
            board_q  <= board_d;
            cursor_q <= cursor_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            play_q   <= playState;
            mov_q    <= mov_d;
            exp_q    <= exp_d;
        end
    end

    assign board       = board_q;
    assign cursor      = cursor_q;
    assign playerMov   = mov_q;
    assign timeExpired = exp_q;

endmodule
